// File: rtl/fpadd_issue_pkg.sv
// fpadd_issue_pkg: shared FSM encoding and constants for the FP adder issue slice.
package fpadd_issue_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/fp_pair_fifo.sv
// fp_pair_fifo: operand-pair FIFO with extra-bit pointers so level reaches DEPTH.
module fp_pair_fifo
  import fpadd_issue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  always_comb begin
    level = wptr_q - rptr_q;
    full = level == FULL_LVL;
    empty = level == '0;
    wptr_d = (push && !full) ? wptr_q + ONE : wptr_q;
    rptr_d = (pop && !empty) ? rptr_q + ONE : rptr_q;
    dout = mem[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fpadd_issue.sv
// fpadd_issue: queues operand pairs and issues them one at a time to a multi-cycle FP adder,
// substituting a quiet NaN with out_err when the adder fails to answer within TIMEOUT cycles.
module fpadd_issue
  import fpadd_issue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          add_start,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  input  logic          add_done,
  input  logic [31:0]   add_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum,
  output logic          out_err,
  output logic [LW-1:0] level
);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] add_a_q, add_a_d, add_b_q, add_b_d, out_sum_q, out_sum_d;
  logic add_start_q, add_start_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [63:0] head;
  logic full, empty, pop, go, tmo, release_hold;
  fp_pair_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(in_valid && !full), .din({in_a, in_b}),
    .pop(pop), .dout(head), .full(full), .empty(empty), .level(level)
  );
  // done is honoured in ISSUE as well as WAIT so single-cycle adder answers are not lost
  always_comb begin
    go = state_q == IDLE && !empty;
    tmo = state_q == WAIT && cnt_q == TMO_LAST;
    pop = (state_q == ISSUE || state_q == WAIT) && (add_done || tmo);
    release_hold = state_q == HOLD && out_ready;
    state_d = go ? ISSUE : pop ? HOLD : state_q == ISSUE ? WAIT : release_hold ? IDLE : state_q;
    cnt_d = state_q == WAIT ? cnt_q + CNT_ONE : '0;
    add_start_d = go;
    add_a_d = go ? head[63:32] : add_a_q;
    add_b_d = go ? head[31:0] : add_b_q;
    out_valid_d = pop ? 1'b1 : release_hold ? 1'b0 : out_valid_q;
    out_sum_d = pop ? (add_done ? add_sum : QNAN) : out_sum_q;
    out_err_d = pop ? !add_done : out_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      add_start_q <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      out_valid_q <= 1'b0;
      out_sum_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      add_start_q <= add_start_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      out_valid_q <= out_valid_d;
      out_sum_q <= out_sum_d;
      out_err_q <= out_err_d;
    end
  end
  assign in_ready = !full;
  assign add_start = add_start_q;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign out_valid = out_valid_q;
  assign out_sum = out_sum_q;
  assign out_err = out_err_q;
endmodule

// File: tb/tb_fpadd_issue.sv
// tb_fpadd_issue: scoreboard bench with a behavioural latency-programmable adder model.
module tb_fpadd_issue;
  import fpadd_issue_pkg::*;
  localparam logic [31:0] HANG_A = 32'h7F7FFFFF;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, add_done = 1'b0, stray = 1'b0;
  logic [31:0] in_a = '0, in_b = '0, add_sum = '0;
  logic in_ready, add_start, out_valid, out_err;
  logic [31:0] add_a, add_b, out_sum;
  logic [2:0] level;
  int errors = 0, checks = 0, starts = 0, results = 0, lat = 6;
  logic [32:0] sb [$];

  fpadd_issue #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_done(add_done), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
  endfunction

  // adder model: answers lat cycles after the start cycle (0 = same cycle), never for HANG_A or lat<0
  initial begin : adder
    int left;
    bit pend;
    logic [31:0] ra, rb;
    pend = 0; left = 0; ra = '0; rb = '0;
    forever begin
      @(posedge clk); #1;
      add_done = 1'b0;
      if (!rst_n) pend = 0;
      else begin
        if (stray) begin add_done = 1'b1; add_sum = 32'hDEADBEEF; end
        if (pend) begin
          if (left == 0) begin add_done = 1'b1; add_sum = fake_add(ra, rb); pend = 0; end
          else left--;
        end
        if (add_start) begin
          starts++;
          ra = add_a; rb = add_b;
          if (ra == HANG_A || lat < 0) ;
          else if (lat == 0) begin add_done = 1'b1; add_sum = fake_add(ra, rb); end
          else begin pend = 1; left = lat - 1; end
        end
      end
    end
  end

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        results++;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", 64'({out_err, out_sum}), 64'(e));
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic err);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        check("push_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back({err, err ? QNAN : fake_add(a, b)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!add_start && n < 300) begin @(posedge clk); #1; n++; end
    check("start_seen", 64'(add_start), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin @(posedge clk); #1; n++; end
    check("drain_left", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int n, s0, r0;
    bit ok;
    logic [31:0] held;
    #12;
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_add_start", 64'(add_start), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_add_ab", 64'({add_a, add_b}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    lat = 6; out_ready = 1'b1; s0 = starts;
    push(32'h3F800000, 32'h40000000, 1'b0);
    drain();
    check("t031_starts", 64'(starts - s0), 64'd1);

    lat = 0;
    push(32'h00000000, 32'h41200000, 1'b0);
    wait_start(n);
    @(posedge clk); #1;
    check("t032_issue_capture", 64'(out_valid), 64'd1);
    check("t032_sum", 64'(out_sum), 64'h41200000);
    drain();

    lat = 20;
    for (int i = 0; i < 4; i++) push(32'h3F000000 + i, 32'h00100000 * (i + 1), 1'b0);
    check("t033_full_ready", 64'(in_ready), 64'd0);
    check("t033_level", 64'(level), 64'd4);
    r0 = results;
    push(32'h40E00000, 32'h00000005, 1'b0);
    check("t033_fifth_after_pop", 64'(results - r0 <= 1 && level == 3'd4), 64'd1);
    drain();

    lat = 3;
    push(HANG_A, 32'h3F800000, 1'b1);
    push(32'h40A00000, 32'h00000007, 1'b0);
    wait_start(n);
    @(posedge clk);
    ok = 1;
    for (int i = 1; i < 64; i++) begin @(posedge clk); #1; if (out_valid) ok = 0; end
    check("t034_quiet_before", 64'(ok), 64'd1);
    @(posedge clk); #1;
    check("t034_valid_at_64", 64'(out_valid), 64'd1);
    check("t034_sum", 64'(out_sum), 64'(QNAN));
    check("t034_err", 64'(out_err), 64'd1);
    drain();

    lat = 2; out_ready = 1'b0;
    push(32'h41000000, 32'h00000011, 1'b0);
    push(32'h42000000, 32'h00000022, 1'b0);
    n = 0;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
    held = out_sum; s0 = starts;
    check("t035_first_sum", 64'(held), 64'(fake_add(32'h41000000, 32'h00000011)));
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_sum !== held || !out_valid) ok = 0;
      if (i == 2) #1 stray = 1'b1;
      if (i == 3) #1 stray = 1'b0;
    end
    check("t035_stable", 64'(ok), 64'd1);
    check("t035_no_start", 64'(starts - s0), 64'd0);
    out_ready = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!add_start && n < 20);
    check("t035_reissue_gap", 64'(n), 64'd2);
    drain();

    lat = -1;
    for (int i = 0; i < 3; i++) push(32'h3F800000, 32'h00000100 + i, 1'b0);
    repeat (5) @(posedge clk);
    check("t036_level_before", 64'(level), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    check("t036_level_async", 64'(level), 64'd0);
    check("t036_valid_async", 64'(out_valid), 64'd0);
    sb.delete();
    r0 = results; s0 = starts; lat = 4;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("t036_no_results", 64'(results - r0), 64'd0);
    check("t036_no_starts", 64'(starts - s0), 64'd0);
    check("t036_in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
